// File: rtl/ai_cmp_pkg.sv
// Shared helpers for the comparer path: default sizes, width calculation
// and lane extraction from a packed feature vector.
// Build option: AI_LANE_DIST_SQUARED_EN selects squared per-lane differences,
// which doubles the per-lane result width (and so SUM_W / ACC_W).
package ai_cmp_pkg;

    localparam int DEF_LANES     = 4;
    localparam int DEF_W         = 8;
    localparam int DEF_FRAME_LEN = 16;

    // Widest half-vector and widest lane get_lane() can handle.
    localparam int MAX_VEC_W  = 1024;
    localparam int MAX_LANE_W = 64;

`ifdef AI_LANE_DIST_SQUARED_EN
    localparam bit SQUARED = 1'b1;
`else
    localparam bit SQUARED = 1'b0;
`endif

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Width of one lane's difference term.
    function automatic int lane_out_width(input int w);
        return SQUARED ? 2 * w : w;
    endfunction

    // Per-vector distance width: every lane at its maximum cannot overflow.
    function automatic int sum_width(input int lanes, input int w);
        return lane_out_width(w) + clog2(lanes);
    endfunction

    // Frame accumulator width, with one spare bit of headroom.
    function automatic int acc_width(input int lanes, input int w, input int frame_len);
        return sum_width(lanes, w) + clog2(frame_len) + 1;
    endfunction

    // Returns lane i of a half-vector of 'lanes' elements of 'w' bits.
    // Lane 0 is the most significant element.
    function automatic logic [MAX_LANE_W-1:0] get_lane(
        input logic [MAX_VEC_W-1:0] vec,
        input int                   i,
        input int                   lanes,
        input int                   w
    );
        logic [MAX_VEC_W-1:0] shifted;
        logic [MAX_VEC_W-1:0] mask;
        shifted = vec >> ((lanes - 1 - i) * w);
        mask    = (MAX_VEC_W'(1) << w) - MAX_VEC_W'(1);
        shifted = shifted & mask;
        return shifted[MAX_LANE_W-1:0];
    endfunction

endpackage

// File: rtl/ai_lane_distance_if.sv
// Bundle of the distance engine's source inputs and result outputs.
// master: the feature sources / consumer side; slave: the engine.
// Widths follow AI_LANE_DIST_SQUARED_EN through the shared package.
interface ai_lane_distance_if #(
    parameter int LANES     = ai_cmp_pkg::DEF_LANES,
    parameter int W         = ai_cmp_pkg::DEF_W,
    parameter int FRAME_LEN = ai_cmp_pkg::DEF_FRAME_LEN
);
    localparam int PAIR_W = 2 * LANES * W;
    localparam int SUM_W  = ai_cmp_pkg::sum_width(LANES, W);
    localparam int ACC_W  = ai_cmp_pkg::acc_width(LANES, W, FRAME_LEN);

    logic              init;
    logic [PAIR_W-1:0] data_a_in;
    logic              rdy_a_in;
    logic [PAIR_W-1:0] data_b_in;
    logic              rdy_b_in;
    logic [SUM_W-1:0]  vec_dist_out;
    logic              vec_rdy_out;
    logic [ACC_W-1:0]  frame_dist_out;
    logic              frame_rdy_out;
    logic              collision_out;

    modport master (
        output init, data_a_in, rdy_a_in, data_b_in, rdy_b_in,
        input  vec_dist_out, vec_rdy_out, frame_dist_out, frame_rdy_out, collision_out
    );

    modport slave (
        input  init, data_a_in, rdy_a_in, data_b_in, rdy_b_in,
        output vec_dist_out, vec_rdy_out, frame_dist_out, frame_rdy_out, collision_out
    );

endinterface

// File: rtl/ai_lane_absdiff.sv
// Single-lane registered |a - b|, or (a - b)^2 when AI_LANE_DIST_SQUARED_EN
// is defined. The square is taken of the magnitude within the same register
// stage, so latency is one clock in both builds.
module ai_lane_absdiff #(
    parameter int W     = 8,
    parameter int OUT_W = W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [OUT_W-1:0] diff_out
);

    logic [W-1:0] mag;

    // Unsigned magnitude; equal operands take the second branch and give 0.
    assign mag = (a > b) ? (a - b) : (b - a);

    // Register the lane term.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff_out <= '0;
        end else begin
`ifdef AI_LANE_DIST_SQUARED_EN
            diff_out <= OUT_W'(mag) * OUT_W'(mag);
`else
            diff_out <= OUT_W'(mag);
`endif
        end
    end

endmodule

// File: rtl/ai_lane_distance.sv
// Per-lane distance engine: arbitrates two sources, computes the L1 distance
// of the "last"/"next" halves at one vector per clock (4-register pipeline:
// input, lane difference, lane sum, output), and sums FRAME_LEN vector
// distances into a frame total.
// Build option: AI_LANE_DIST_SQUARED_EN gives squared-Euclidean distance.
module ai_lane_distance
    import ai_cmp_pkg::*;
#(
    parameter int LANES     = DEF_LANES,
    parameter int W         = DEF_W,
    parameter int FRAME_LEN = DEF_FRAME_LEN
) (
    input logic               clk,
    input logic               rst,
    ai_lane_distance_if.slave bus
);

    localparam int HALF_W = LANES * W;
    localparam int PAIR_W = 2 * HALF_W;
    localparam int D_W    = lane_out_width(W);
    localparam int SUM_W  = sum_width(LANES, W);
    localparam int ACC_W  = acc_width(LANES, W, FRAME_LEN);
    localparam int CNT_W  = clog2(FRAME_LEN + 1);

    logic              s0_valid_reg;
    logic [PAIR_W-1:0] s0_data_reg;
    logic              collision_reg;
    logic              s1_valid_reg;
    logic [D_W-1:0]    lane_diff [LANES];
    logic [SUM_W-1:0]  lane_sum;
    logic              s2_valid_reg;
    logic [SUM_W-1:0]  s2_sum_reg;
    logic              vec_rdy_reg;
    logic [SUM_W-1:0]  vec_dist_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              frame_rdy_reg;
    logic [ACC_W-1:0]  frame_dist_reg;
    logic [MAX_VEC_W-1:0] last_ext;
    logic [MAX_VEC_W-1:0] next_ext;

    // Stage 0: source A has priority; an idle or init cycle zeroes the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_reg  <= 1'b0;
            s0_data_reg   <= '0;
            collision_reg <= 1'b0;
        end else begin
            collision_reg <= bus.rdy_a_in & bus.rdy_b_in;
            if (bus.init) begin
                s0_valid_reg <= 1'b0;
                s0_data_reg  <= '0;
            end else if (bus.rdy_a_in) begin
                s0_valid_reg <= 1'b1;
                s0_data_reg  <= bus.data_a_in;
            end else if (bus.rdy_b_in) begin
                s0_valid_reg <= 1'b1;
                s0_data_reg  <= bus.data_b_in;
            end else begin
                s0_valid_reg <= 1'b0;
                s0_data_reg  <= '0;
            end
        end
    end

    assign last_ext = MAX_VEC_W'(s0_data_reg[PAIR_W-1:HALF_W]);
    assign next_ext = MAX_VEC_W'(s0_data_reg[HALF_W-1:0]);

    // Stage 1: one registered difference unit per lane.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [W-1:0] last_lane;
            logic [W-1:0] next_lane;
            assign last_lane = W'(get_lane(last_ext, gi, LANES, W));
            assign next_lane = W'(get_lane(next_ext, gi, LANES, W));
            ai_lane_absdiff #(
                .W     (W),
                .OUT_W (D_W)
            ) u_absdiff (
                .clk      (clk),
                .rst      (rst),
                .a        (last_lane),
                .b        (next_lane),
                .diff_out (lane_diff[gi])
            );
        end
    endgenerate

    // Lane adder: SUM_W holds LANES maximal terms, so no wrap is possible.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + SUM_W'(lane_diff[i]);
        end
    end

    // Valid tracking for stages 1/2 and the stage-2 sum register; init kills in-flight data.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_sum_reg   <= '0;
        end else begin
            s1_valid_reg <= s0_valid_reg & ~bus.init;
            s2_valid_reg <= s1_valid_reg & ~bus.init;
            s2_sum_reg   <= lane_sum;
        end
    end

    // Output register: distance holds its last value between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_rdy_reg  <= 1'b0;
            vec_dist_reg <= '0;
        end else begin
            vec_rdy_reg <= s2_valid_reg & ~bus.init;
            if (s2_valid_reg && !bus.init) begin
                vec_dist_reg <= s2_sum_reg;
            end
        end
    end

    // Frame accumulator: a full count is published one edge later, and a
    // vector arriving on that edge starts the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg        <= '0;
            cnt_reg        <= '0;
            frame_rdy_reg  <= 1'b0;
            frame_dist_reg <= '0;
        end else if (bus.init) begin
            acc_reg       <= '0;
            cnt_reg       <= '0;
            frame_rdy_reg <= 1'b0;
        end else if (cnt_reg == CNT_W'(FRAME_LEN)) begin
            frame_dist_reg <= acc_reg;
            frame_rdy_reg  <= 1'b1;
            if (vec_rdy_reg) begin
                acc_reg <= ACC_W'(vec_dist_reg);
                cnt_reg <= CNT_W'(1);
            end else begin
                acc_reg <= '0;
                cnt_reg <= '0;
            end
        end else begin
            frame_rdy_reg <= 1'b0;
            if (vec_rdy_reg) begin
                acc_reg <= acc_reg + ACC_W'(vec_dist_reg);
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign bus.vec_dist_out   = vec_dist_reg;
    assign bus.vec_rdy_out    = vec_rdy_reg;
    assign bus.frame_dist_out = frame_dist_reg;
    assign bus.frame_rdy_out  = frame_rdy_reg;
    assign bus.collision_out  = collision_reg;

endmodule

// File: tb/tb_ai_lane_distance.sv
// Directed bench for ai_lane_distance with default parameters (L1 build).
// A negedge monitor logs every output pulse with its cycle number; the test
// sequence drives inputs on negedges and checks the logs against hand values.
module tb_ai_lane_distance;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;

    ai_lane_distance_if bus ();

    ai_lane_distance dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Lane 0 is the leftmost byte of each half: {last0..last3, next0..next3}.
    localparam logic [63:0] V60    = {8'd10, 8'd20, 8'd30, 8'd40, 8'd15, 8'd5, 8'd30, 8'd0};
    localparam logic [63:0] V1020  = {32'hFFFF_FFFF, 32'h0000_0000};
    localparam logic [63:0] V1020R = {32'h0000_0000, 32'hFFFF_FFFF};
    localparam logic [63:0] VEQ    = 64'h0707_0707_0707_0707;
    localparam logic [63:0] V8     = {8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [63:0] V150   = {8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd50};

    typedef struct {
        logic [63:0] data;
        logic        use_b;
        int          exp;
        string       name;
    } vec_t;

    vec_t tbl [6];

    int vq_val [$];
    int vq_cyc [$];
    int fq_val [$];
    int fq_cyc [$];
    int coll_cyc [$];

    int errors = 0;
    int checks = 0;
    int base, fbase, cbase, d, n, s;

    // Cycle counter: value seen at a negedge = number of posedges so far.
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor.
    always @(negedge clk) begin
        if (bus.vec_rdy_out === 1'b1) begin
            vq_val.push_back(int'(bus.vec_dist_out));
            vq_cyc.push_back(cyc);
        end
        if (bus.frame_rdy_out === 1'b1) begin
            fq_val.push_back(int'(bus.frame_dist_out));
            fq_cyc.push_back(cyc);
        end
        if (bus.collision_out === 1'b1) begin
            coll_cyc.push_back(cyc);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Presents one cycle of inputs, then returns to idle at the next negedge.
    task automatic send(input logic [63:0] a, input logic va, input logic [63:0] b,
                        input logic vb, input logic ini);
        bus.data_a_in = a;
        bus.rdy_a_in  = va;
        bus.data_b_in = b;
        bus.rdy_b_in  = vb;
        bus.init      = ini;
        @(negedge clk);
        bus.data_a_in = '0;
        bus.rdy_a_in  = 1'b0;
        bus.data_b_in = '0;
        bus.rdy_b_in  = 1'b0;
        bus.init      = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) send('0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic stream(input logic [63:0] data, input int count);
        repeat (count) send(data, 1'b1, '0, 1'b0, 1'b0);
    endtask

    initial begin
        tbl[0] = '{V60,    1'b0, 60,   "mixed"};
        tbl[1] = '{V1020,  1'b0, 1020, "max"};
        tbl[2] = '{VEQ,    1'b0, 0,    "equal"};
        tbl[3] = '{V1020R, 1'b0, 1020, "max_rev"};
        tbl[4] = '{V8,     1'b0, 8,    "cross"};
        tbl[5] = '{V150,   1'b1, 150,  "src_b"};

        rst           = 1'b1;
        bus.init      = 1'b0;
        bus.data_a_in = '0;
        bus.rdy_a_in  = 1'b0;
        bus.data_b_in = '0;
        bus.rdy_b_in  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("reset vec_rdy", int'(bus.vec_rdy_out), 0);
        check("reset vec_dist", int'(bus.vec_dist_out), 0);
        check("reset frame_rdy", int'(bus.frame_rdy_out), 0);
        check("reset frame_dist", int'(bus.frame_dist_out), 0);
        check("reset collision", int'(bus.collision_out), 0);
        rst = 1'b0;
        idle(2);

        // Single vectors: value and 4-cycle latency.
        for (int i = 0; i < 6; i++) begin
            base = vq_val.size();
            d    = cyc;
            if (tbl[i].use_b) send('0, 1'b0, tbl[i].data, 1'b1, 1'b0);
            else              send(tbl[i].data, 1'b1, '0, 1'b0, 1'b0);
            idle(6);
            check({tbl[i].name, " count"}, vq_val.size() - base, 1);
            if (vq_val.size() > base) begin
                check({tbl[i].name, " value"}, vq_val[base], tbl[i].exp);
                check({tbl[i].name, " latency"}, vq_cyc[base] - d, 4);
            end
            $display("vector %s: dist=%0d", tbl[i].name, (vq_val.size() > base) ? vq_val[base] : -1);
        end

        // Collision: A wins, B (1020) dropped, one collision pulse next cycle.
        base  = vq_val.size();
        cbase = coll_cyc.size();
        d     = cyc;
        send(V60, 1'b1, V1020, 1'b1, 1'b0);
        idle(6);
        check("collision vec count", vq_val.size() - base, 1);
        if (vq_val.size() > base) check("collision vec value", vq_val[base], 60);
        check("collision pulses", coll_cyc.size() - cbase, 1);
        if (coll_cyc.size() > cbase) check("collision timing", coll_cyc[cbase] - d, 1);
        check("no frame before 16", fq_val.size(), 0);
        $display("collision: pulses=%0d", coll_cyc.size() - cbase);

        // Clear the 7-vector partial frame, then stream 32 back-to-back:
        // 16 x 60, then 1020 seeding the next frame, then 15 x 8.
        send('0, 1'b0, '0, 1'b0, 1'b1);
        idle(6);
        check("init keeps frame_dist", int'(bus.frame_dist_out), 0);
        base  = vq_val.size();
        fbase = fq_val.size();
        d     = cyc;
        stream(V60, 16);
        send(V1020, 1'b1, '0, 1'b0, 1'b0);
        stream(V8, 15);
        idle(10);
        n = vq_val.size() - base;
        check("stream count", n, 32);
        s = 0;
        for (int k = 0; k < n; k++) s += vq_val[base + k];
        check("stream sum", s, 2100);
        if (n == 32) begin
            check("stream first latency", vq_cyc[base] - d, 4);
            check("stream contiguous", vq_cyc[base + 31] - vq_cyc[base], 31);
        end
        check("stream frames", fq_val.size() - fbase, 2);
        if (fq_val.size() - fbase >= 2 && n == 32) begin
            check("frame1 value", fq_val[fbase], 960);
            check("frame1 timing", fq_cyc[fbase] - vq_cyc[base + 15], 2);
            check("frame2 value", fq_val[fbase + 1], 1140);
            check("frame2 timing", fq_cyc[fbase + 1] - vq_cyc[base + 31], 2);
        end
        check("frame_dist holds", int'(bus.frame_dist_out), 1140);
        $display("stream: vectors=%0d frames=%0d", n, fq_val.size() - fbase);

        // init with two vectors in flight (plus a strobe in the init cycle).
        base  = vq_val.size();
        fbase = fq_val.size();
        stream(V60, 5);
        idle(1);
        send(V1020, 1'b1, '0, 1'b0, 1'b1);
        idle(8);
        check("init flush count", vq_val.size() - base, 3);
        check("init no frame", fq_val.size() - fbase, 0);
        check("init frame_dist kept", int'(bus.frame_dist_out), 1140);
        stream(V8, 16);
        idle(10);
        check("post-init frames", fq_val.size() - fbase, 1);
        if (fq_val.size() > fbase) check("post-init frame value", fq_val[fbase], 128);
        $display("init: emitted=%0d", vq_val.size() - base);

        // rst mid-stream with strobes active.
        stream(V60, 3);
        bus.data_a_in = V60;
        bus.data_b_in = V1020;
        bus.rdy_a_in  = 1'b1;
        bus.rdy_b_in  = 1'b1;
        rst           = 1'b1;
        @(negedge clk);
        bus.rdy_a_in  = 1'b0;
        bus.rdy_b_in  = 1'b0;
        @(negedge clk);
        check("rst vec_rdy", int'(bus.vec_rdy_out), 0);
        check("rst vec_dist", int'(bus.vec_dist_out), 0);
        check("rst frame_dist", int'(bus.frame_dist_out), 0);
        check("rst frame_rdy", int'(bus.frame_rdy_out), 0);
        check("rst collision", int'(bus.collision_out), 0);
        rst   = 1'b0;
        base  = vq_val.size();
        fbase = fq_val.size();
        idle(6);
        check("rst no leak", vq_val.size() - base, 0);
        d = cyc;
        send(V60, 1'b1, '0, 1'b0, 1'b0);
        idle(6);
        check("post-rst count", vq_val.size() - base, 1);
        if (vq_val.size() > base) begin
            check("post-rst value", vq_val[base], 60);
            check("post-rst latency", vq_cyc[base] - d, 4);
        end
        stream(V8, 14);
        idle(8);
        check("post-rst 15 no frame", fq_val.size() - fbase, 0);
        stream(V8, 1);
        idle(8);
        check("post-rst frames", fq_val.size() - fbase, 1);
        if (fq_val.size() > fbase) check("post-rst frame value", fq_val[fbase], 180);
        $display("rst: frames after 16 vectors=%0d", fq_val.size() - fbase);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ai_lane_distance.md
Name: ai_lane_distance

Overview:
- Parametrised per-lane absolute-difference distance engine for the comparer path.
- Takes a packed pair of feature vectors ("last" and "next") from one of two priority-arbitrated sources.
- Computes the L1 distance per vector, fully pipelined at one vector per clock.
- Also accumulates a per-frame total distance over FRAME_LEN vectors, for the keyword-match scorer downstream.

Parameters:
LANES, 4, number of feature lanes per vector (>=2, power of two)
W, 8, unsigned bits per lane element
FRAME_LEN, 16, vectors summed into one frame total (>=1)
Derived (localparam): SUM_W = W + clog2(LANES); ACC_W = SUM_W + clog2(FRAME_LEN) + 1

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
init  in  1  clear frame accumulator and flush pipeline
data_a_in  in  2*LANES*W  packed pair, source A (high priority)
rdy_a_in  in  1  source A valid strobe
data_b_in  in  2*LANES*W  packed pair, source B (low priority)
rdy_b_in  in  1  source B valid strobe
vec_dist_out  out  SUM_W  per-vector L1 distance
vec_rdy_out  out  1  vec_dist_out valid pulse
frame_dist_out  out  ACC_W  frame total distance
frame_rdy_out  out  1  frame_dist_out valid pulse
collision_out  out  1  pulse: both strobes high, B dropped

Behaviour:
- Packing:
  - Upper half [2*LANES*W-1:LANES*W] is "last"; lower half is "next".
  - Lane 0 occupies the MSB element of each half.
- Stage 0 (input register):
  - rdy_a_in wins; else rdy_b_in; else the stage is invalid and its data register is zeroed.
  - collision_out is registered and pulses one cycle after both strobes are high.
- Stage 1: per lane, register |last_i - next_i| (unsigned, W bits); compare with >, equal gives 0.
- Stage 2: register the sum of all lanes in SUM_W bits; no overflow is possible by construction.
- Output register: vec_dist_out / vec_rdy_out are valid 4 clocks after the accepting edge.
  - Back-to-back inputs produce back-to-back outputs; no bubbles, no backpressure.
- Frame accumulator:
  - On each vec_rdy_out, acc += vec_dist_out and cnt += 1.
  - When cnt reaches FRAME_LEN, on the next edge: frame_dist_out = acc, frame_rdy_out = 1 for one cycle, acc and cnt return to 0.
  - A vector arriving in that same cycle seeds the new frame (acc = its distance, cnt = 1).
- frame_dist_out holds its value until the next frame; vec_dist_out holds its last value, valid only with vec_rdy_out.
- init (synchronous, one cycle):
  - Invalidates all in-flight stages and clears acc and cnt.
  - An input strobed in the same cycle as init is dropped.
  - Does not change frame_dist_out.
  - No vec_rdy_out or frame_rdy_out pulse may result from data accepted before or during init.
- rst: all registers and outputs go to 0, including frame_dist_out, collision_out and all rdy outputs, on the next edge; same flush semantics as init.
- Partial frames: discarded only by init or rst; otherwise they persist indefinitely across idle gaps.

Optional Feature:
- Macro: AI_LANE_DIST_SQUARED_EN.
- When defined:
  - Stage 1 computes (last_i - next_i)^2 in 2W bits.
  - SUM_W becomes 2W + clog2(LANES), giving a squared-Euclidean distance; ACC_W follows from SUM_W.
  - Latency is unchanged: the multiply is registered within stage 1.
- When undefined: plain L1 as specified above.

Decomposition:
- Shared package ai_cmp_pkg holds:
  - function clog2;
  - localparams for the default LANES/W/FRAME_LEN;
  - the packing helper function get_lane(vec, i) that returns lane i.
- One natural sub-module, ai_lane_absdiff: a single-lane registered |a-b| (or squared under the macro), instantiated LANES times in a generate loop. The adder tree and the accumulator stay in the top.

Test Plan:
1. Defaults. A: last={10,20,30,40}, next={15,5,30,0} -> vec_rdy_out 4 cycles later, vec_dist_out=60.
2. Collision. rdy_a and rdy_b same cycle, B = all lanes 255 vs 0 -> only A's distance emitted; collision_out pulses once; no 1020 output.
3. Streaming. 16 consecutive vectors, each distance 60 -> 16 contiguous vec_rdy pulses; frame_rdy_out one cycle after the 16th; frame_dist_out=960.
4. Boundary lanes. All last=255, next=0 -> vec_dist_out=1020 (max, no wrap). Equal vectors -> 0.
5. init mid-frame. 5 vectors, then init while 2 are in flight -> no further vec_rdy; next 16 vectors give a frame total covering only those 16.
6. rst mid-stream, then the test-1 vector -> all outputs 0 after reset; the first result is 60 at 4-cycle latency; a 16-vector frame is needed before frame_rdy.
